// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its control_unit neighbour.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

  // Fetch FSM encoding (2-bit)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Opcode / funct values decoded by control_unit from instr[31:26] / instr[5:0]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// Next-PC selection: JR > jump > taken branch > sequential.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is committed.
// Ports: pc_i (current PC), instr_lo_i (instr[25:0]), pcsrc1/2/3_i (steering),
//        jr_tgt_i (jr_target[31:2]), pc_plus4_o, next_pc_o.
module next_pc_logic (
  input  logic [31:0] pc_i,
  input  logic [25:0] instr_lo_i,
  input  logic        pcsrc1_i,
  input  logic        pcsrc2_i,
  input  logic        pcsrc3_i,
  input  logic [29:0] jr_tgt_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] br_off;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign pc_plus4_o = pc_i + 32'd4;
  // Sign-extended word offset of the 16-bit immediate
  assign br_off     = {{14{instr_lo_i[15]}}, instr_lo_i[15:0], 2'b00};
  assign br_target  = pc_plus4_o + br_off;
  assign j_target   = {pc_plus4_o[31:28], instr_lo_i, 2'b00};

  always_comb begin
    next_pc_o = pc_plus4_o;
    if (pcsrc3_i) begin
      next_pc_o = {jr_tgt_i, 2'b00};
    end else if (pcsrc1_i) begin
      next_pc_o = j_target;
    end else if (pcsrc2_i) begin
      next_pc_o = br_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, reads imem via req/ack, presents instr for one EXEC cycle.
// Latency: 2 cycles/instruction minimum (FETCH + EXEC), plus one cycle per cycle of ack delay.
// Backpressure: stall holds EXEC (instr and pc frozen); missing ack for TIMEOUT cycles halts the unit.
// Ports: clk/rst_n; imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
//        instr/instr_valid/pc/pc_plus4 to decode; PCSrc1/2/3, jr_target, stall from control;
//        fetch_err sticky timeout flag.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        PCSrc1,
  input  logic        PCSrc2,
  input  logic        PCSrc3,
  input  logic [31:0] jr_target,
  input  logic        stall,
  output logic        fetch_err
);

  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] next_pc;

  next_pc_logic u_next_pc (
    .pc_i       (pc_q),
    .instr_lo_i (instr_q[25:0]),
    .pcsrc1_i   (PCSrc1),
    .pcsrc2_i   (PCSrc2),
    .pcsrc3_i   (PCSrc3),
    .jr_tgt_i   (jr_target[31:2]),
    .pc_plus4_o (pc_plus4),
    .next_pc_o  (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_EXEC: begin
        // Steering inputs only matter here, on the non-stalled cycle
        if (!stall) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_HALT; // HALT is left only through reset
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign pc          = pc_q;
  assign fetch_err   = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        PCSrc1, PCSrc2, PCSrc3;
  logic [31:0] jr_target;
  logic        stall;
  logic        fetch_err;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];  // expected fetch addresses, pushed when PC steering is driven
  logic [31:0] m_pc;

  fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .PCSrc1(PCSrc1), .PCSrc2(PCSrc2), .PCSrc3(PCSrc3),
    .jr_target(jr_target), .stall(stall), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent reference for next PC
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic s1, input logic s2, input logic s3,
                                           input logic [31:0] jr);
    logic [31:0] seq;
    logic [31:0] off;
    seq = p + 32'd4;
    off = 32'($signed(w[15:0])) << 2;
    if (s3)      return jr & 32'hFFFF_FFFC;
    else if (s1) return {seq[31:28], w[25:0], 2'b00};
    else if (s2) return seq + off;
    else         return seq;
  endfunction

  task automatic wait_req();
    int waited = 0;
    while (!imem_req && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic pop_addr();
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("imem_addr", imem_addr, e);
    end
  endtask

  // One full instruction: FETCH with ack_dly cycles of delay, EXEC with stall_cyc stall cycles.
  task automatic run_instr(input logic [31:0] word, input int ack_dly, input int stall_cyc,
                           input logic s1, input logic s2, input logic s3, input logic [31:0] jr);
    logic [31:0] a0;
    logic [31:0] nxt;
    int vcnt;
    wait_req();
    pop_addr();
    a0 = imem_addr;
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk("req_hold", {31'b0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, a0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("instr", instr, word);
    chk("exec_req", {31'b0, imem_req}, 32'd0);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    vcnt = 0;
    if (instr_valid) vcnt++;
    for (int i = 0; i < stall_cyc; i++) begin
      stall = 1'b1;
      // Steering must be ignored while stalled
      PCSrc3 = 1'b1; jr_target = 32'h0BAD_0000;
      @(negedge clk);
      if (instr_valid) vcnt++;
      chk("stall_pc", pc, m_pc);
    end
    stall = 1'b0;
    PCSrc1 = s1; PCSrc2 = s2; PCSrc3 = s3; jr_target = jr;
    nxt = ref_next(m_pc, word, s1, s2, s3, jr);
    exp_q.push_back(nxt);
    m_pc = nxt;
    @(negedge clk);
    PCSrc1 = 1'b0; PCSrc2 = 1'b0; PCSrc3 = 1'b0; jr_target = 32'h0;
    chk("valid_cycles", vcnt, stall_cyc + 1);
    chk("valid_drop", {31'b0, instr_valid}, 32'd0);
    chk("pc_commit", pc, nxt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_pc = 32'h0;
    exp_q.push_back(32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    PCSrc1 = 1'b0; PCSrc2 = 1'b0; PCSrc3 = 1'b0; jr_target = 32'h0;
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    do_reset();
    // IDLE for one cycle after reset: no request yet
    chk("idle_req", {31'b0, imem_req}, 32'd0);

    // 1: sequential fetch at 0 -> 4
    run_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    // jump to 0x10
    run_instr(32'h0800_0004, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    // 2: branch +3 words -> 0x20, then imm -1 -> self-loop at 0x20
    run_instr(32'h1000_0003, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0);
    run_instr(32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0);
    // jump to 0x40
    run_instr(32'h0800_0010, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    // 3: jump beats branch -> 0x400
    run_instr(32'h0800_0100, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0);
    // 4: JR beats jump, low bits cleared -> 0x1234
    run_instr(32'h0800_0100, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_1237);
    // JR to top word, then sequential wrap to 0
    run_instr(32'h0000_0008, 0, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    // 5: ack delayed 5 cycles, 3 stall cycles
    run_instr(32'h2009_0007, 5, 3, 1'b0, 1'b0, 1'b0, 32'h0);

    // 6: no ack at 0x4 -> halt after TMO FETCH cycles
    wait_req();
    pop_addr();
    for (int i = 1; i < TMO; i++) begin
      @(negedge clk);
      chk("tmo_req", {31'b0, imem_req}, 32'd1);
    end
    chk("tmo_err_pre", {31'b0, fetch_err}, 32'd0);
    @(negedge clk);
    chk("tmo_err", {31'b0, fetch_err}, 32'd1);
    chk("tmo_req_off", {31'b0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    chk("halt_sticky", {31'b0, fetch_err}, 32'd1);
    chk("halt_valid", {31'b0, instr_valid}, 32'd0);

    // Recover via reset, move PC away from 0, then reset mid-FETCH
    do_reset();
    run_instr(32'h0800_0020, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    wait_req();
    pop_addr();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_req", {31'b0, imem_req}, 32'd0);
    chk("async_instr", instr, 32'h0);
    chk("async_err", {31'b0, fetch_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
